// File: rtl/weight_load_sequencer.sv
// Steers a stream of weight words into per-layer weight stores, one layer at a time,
// masking each word to the target layer's nerve count and weight bitsize.
module weight_load_sequencer #(
  parameter int NumLayers    = 3,
  parameter int MaxNumNerves = 4,
  parameter int M_W_BitSize  = 8,
  parameter int FirstDepth   = 4,
  parameter int LNN [NumLayers-1:0] = '{2, 2, 3},
  parameter int LWB [NumLayers-1:0] = '{2, 8, 4}
) (
  input  logic                                clk,
  input  logic                                res_n,
  input  logic                                in_start,
  input  logic                                in_single,
  input  logic [$clog2(NumLayers):0]          in_layer_sel,
  input  logic                                in_abort,
  input  logic                                in_valid,
  input  logic [MaxNumNerves*M_W_BitSize-1:0] in_weights,
  output logic                                in_ready,
  output logic [NumLayers-1:0]                out_w_en,
  output logic [MaxNumNerves*M_W_BitSize-1:0] out_weights,
  output logic [NumLayers-1:0]                out_layer_clr,
  output logic [NumLayers-1:0]                out_layer_loaded,
  output logic                                out_all_loaded,
  output logic                                out_busy,
  output logic                                out_done,
  output logic                                out_err,
  output logic [1:0]                          dbg_state
);

  localparam int WW = MaxNumNerves * M_W_BitSize;
  localparam int LW = $clog2(NumLayers) + 1;

  // Layer k is fed by the previous layer's nerves; layer 0 by the flattened image.
  function automatic int depth_of(input int k);
    if (k == 0) return FirstDepth;
    return LNN[k-1];
  endfunction

  function automatic int max_depth();
    int m;
    m = 1;
    for (int k = 0; k < NumLayers; k++) begin
      if (depth_of(k) > m) m = depth_of(k);
    end
    return m;
  endfunction

  function automatic logic [M_W_BitSize-1:0] bit_mask(input int b);
    logic [M_W_BitSize-1:0] m;
    for (int i = 0; i < M_W_BitSize; i++) m[i] = (i < b);
    return m;
  endfunction

  localparam int MaxD = max_depth();
  localparam int CW   = $clog2(MaxD) + 1;

  typedef enum logic [1:0] {IDLE, PREP, LOAD, DONE} state_t;

  state_t              state_q, state_d;
  logic [LW-1:0]       cur_q, cur_d;
  logic [LW-1:0]       last_q, last_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NumLayers-1:0] loaded_q, loaded_d;
  logic                err_q, err_d;

  logic [NumLayers-1:0] cur_onehot;
  logic [WW-1:0]        cur_mask;
  logic                 cur_last_word;
  logic                 accept;

  // Per-layer constants selected by the current layer index.
  always_comb begin
    cur_onehot    = '0;
    cur_mask      = '0;
    cur_last_word = 1'b0;
    for (int k = 0; k < NumLayers; k++) begin
      if (cur_q == LW'(k)) begin
        cur_onehot[k] = 1'b1;
        cur_last_word = (cnt_q == CW'(depth_of(k) - 1));
        for (int n = 0; n < MaxNumNerves; n++) begin
          if (n < LNN[k]) cur_mask[n*M_W_BitSize +: M_W_BitSize] = bit_mask(LWB[k]);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge res_n) begin
    if (res_n) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      last_q   <= '0;
      cnt_q    <= '0;
      loaded_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
    end
  end

  // Handshake: a word transfers on a rising clk edge when in_valid && in_ready;
  // in_ready is high only in LOAD and drops in the same cycle in_abort is raised.
  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    loaded_d      = loaded_q;
    err_d         = 1'b0;
    in_ready      = 1'b0;
    accept        = 1'b0;
    out_layer_clr = '0;
    case (state_q)
      IDLE: begin
        if (in_start) begin
          if (!in_single) begin
            cur_d   = '0;
            last_d  = LW'(NumLayers - 1);
            state_d = PREP;
          end else if (in_layer_sel < LW'(NumLayers)) begin
            cur_d   = in_layer_sel;
            last_d  = in_layer_sel;
            state_d = PREP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PREP: begin
        out_layer_clr = cur_onehot;
        loaded_d      = loaded_q & ~cur_onehot;
        cnt_d         = '0;
        state_d       = in_abort ? IDLE : LOAD;
      end
      LOAD: begin
        in_ready = !in_abort;
        accept   = in_ready && in_valid;
        if (in_abort) begin
          state_d = IDLE;
        end else if (accept) begin
          cnt_d = cnt_q + CW'(1);
          if (cur_last_word) begin
            loaded_d = loaded_q | cur_onehot;
            if (cur_q == last_q) begin
              state_d = DONE;
            end else begin
              cur_d   = cur_q + LW'(1);
              state_d = PREP;
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign out_w_en         = accept ? cur_onehot : '0;
  assign out_weights      = accept ? (in_weights & cur_mask) : '0;
  assign out_layer_loaded = loaded_q;
  assign out_all_loaded   = &loaded_q;
  assign out_busy         = (state_q == PREP) || (state_q == LOAD);
  assign out_done         = (state_q == DONE);
  assign out_err          = err_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_weight_load_sequencer.sv
// Directed bench for weight_load_sequencer at default parameters: cycle-exact
// sequencing checks plus a scoreboard of masked weight writes.
module tb_weight_load_sequencer;

  localparam int NL = 3;
  localparam int WW = 32;
  localparam int SW = NL + WW;
  localparam int T_LNN [3] = '{3, 2, 2};
  localparam int T_LWB [3] = '{4, 8, 2};

  logic          clk = 1'b0;
  logic          res_n;
  logic          in_start, in_single, in_abort, in_valid;
  logic [2:0]    in_layer_sel;
  logic [WW-1:0] in_weights;
  logic          in_ready;
  logic [NL-1:0] out_w_en, out_layer_clr, out_layer_loaded;
  logic [WW-1:0] out_weights;
  logic          out_all_loaded, out_busy, out_done, out_err;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad   = 0;
  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] sb_exp;

  weight_load_sequencer dut (
    .clk(clk), .res_n(res_n), .in_start(in_start), .in_single(in_single),
    .in_layer_sel(in_layer_sel), .in_abort(in_abort), .in_valid(in_valid),
    .in_weights(in_weights), .in_ready(in_ready), .out_w_en(out_w_en),
    .out_weights(out_weights), .out_layer_clr(out_layer_clr),
    .out_layer_loaded(out_layer_loaded), .out_all_loaded(out_all_loaded),
    .out_busy(out_busy), .out_done(out_done), .out_err(out_err),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic int t_depth(input int k);
    return (k == 0) ? 4 : T_LNN[k-1];
  endfunction

  function automatic logic [WW-1:0] t_mask(input logic [WW-1:0] w, input int k);
    logic [WW-1:0] r;
    logic [7:0] m;
    r = '0;
    m = 8'((1 << T_LWB[k]) - 1);
    for (int n = 0; n < 4; n++) begin
      if (n < T_LNN[k]) r[n*8 +: 8] = w[n*8 +: 8] & m;
    end
    return r;
  endfunction

  function automatic logic [NL-1:0] onehot(input int k);
    return NL'(1 << k);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s check failed", tag);
    end
  endtask

  // Scoreboard: every write the DUT issues must match the next expected masked word.
  always @(negedge clk) begin
    if (res_n === 1'b0 && out_w_en !== '0) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_write", {out_w_en, out_weights}, '0);
      end else begin
        sb_exp = exp_q.pop_front();
        check("sb_write", {out_w_en, out_weights}, sb_exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_prep(input int k);
    @(negedge clk);
    check("prep_clr", out_layer_clr, onehot(k));
    check("prep_ready", in_ready, 1'b0);
    check("prep_busy", out_busy, 1'b1);
    step();
  endtask

  task automatic do_word(input int k, input logic [WW-1:0] w);
    in_weights = w;
    exp_q.push_back({onehot(k), t_mask(w, k)});
    @(negedge clk);
    check("load_ready", in_ready, 1'b1);
    check("load_wen", out_w_en, onehot(k));
    check("load_clr", out_layer_clr, '0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    res_n = 1'b1; in_start = 0; in_single = 0; in_layer_sel = '0;
    in_abort = 0; in_valid = 0; in_weights = '0;

    // Reset state
    @(negedge clk);
    check("rst_outputs", {in_ready, out_w_en, out_weights, out_layer_clr, out_busy, out_done, out_err}, '0);
    check("rst_loaded", {out_layer_loaded, out_all_loaded}, '0);
    step();
    res_n = 1'b0;
    step();

    // Full load with in_valid held high
    in_valid = 1; in_start = 1; in_single = 0;
    step();
    in_start = 0;
    for (int k = 0; k < NL; k++) begin
      do_prep(k);
      for (int w = 0; w < t_depth(k); w++) begin
        if (w == 0 && k != 1) begin
          in_weights = 32'hFFFF_FFFF;
          exp_q.push_back({onehot(k), t_mask(in_weights, k)});
          @(negedge clk);
          check(k == 0 ? "mask_layer0" : "mask_layer2", out_weights,
                k == 0 ? 32'h000F_0F0F : 32'h0000_0303);
          step();
        end else begin
          do_word(k, $urandom());
        end
      end
    end
    @(negedge clk);
    check("full_done", out_done, 1'b1);
    check("full_loaded", {out_layer_loaded, out_all_loaded}, 4'b1111);
    check("full_busy_done", out_busy, 1'b0);
    step();
    in_valid = 0;
    @(negedge clk);
    check("full_done_pulse", out_done, 1'b0);
    step();

    // Single reload of layer 1 with valid bubbles; start during LOAD is ignored
    in_start = 1; in_single = 1; in_layer_sel = 3'd1;
    step();
    in_start = 0;
    do_prep(1);
    for (int p = 0; p < 5; p++) begin
      in_valid = (p % 2 == 0);
      in_start = (p % 2 == 1);
      in_weights = $urandom();
      if (in_valid) exp_q.push_back({onehot(1), t_mask(in_weights, 1)});
      @(negedge clk);
      check("single_wen", out_w_en, in_valid ? onehot(1) : 3'b000);
      check("single_clr", out_layer_clr, '0);
      if (p == 0) check("single_loaded_cleared", out_layer_loaded, 3'b101);
      step();
    end
    in_valid = 0; in_start = 0;
    @(negedge clk);
    check("single_done", out_done, 1'b1);
    check("single_loaded", out_layer_loaded, 3'b111);
    step();

    // Out-of-range single layer
    in_start = 1; in_single = 1; in_layer_sel = 3'd3;
    step();
    in_start = 0;
    @(negedge clk);
    check("err_pulse", out_err, 1'b1);
    check("err_busy", out_busy, 1'b0);
    step();
    @(negedge clk);
    check("err_pulse_end", {out_err, out_busy}, 2'b00);
    check("err_loaded", out_layer_loaded, 3'b111);
    step();

    // Reset asserted during LOAD
    in_single = 0; in_valid = 1; in_start = 1;
    step();
    in_start = 0;
    do_prep(0);
    in_weights = $urandom();
    exp_q.push_back({onehot(0), t_mask(in_weights, 0)});
    @(negedge clk);
    #1 res_n = 1'b1;
    #1;
    check("midrst_outputs", {in_ready, out_w_en, out_weights, out_busy, out_done}, '0);
    check("midrst_loaded", {out_layer_loaded, out_all_loaded}, '0);
    step();
    in_valid = 0;
    res_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_done", {out_done, out_busy}, 2'b00);
      step();
    end

    // Abort on the second layer-1 accept
    in_valid = 1; in_start = 1;
    step();
    in_start = 0;
    do_prep(0);
    for (int w = 0; w < 4; w++) do_word(0, $urandom());
    do_prep(1);
    do_word(1, $urandom());
    in_abort = 1;
    in_weights = $urandom();
    @(negedge clk);
    check("abort_ready", in_ready, 1'b0);
    check("abort_wen", out_w_en, '0);
    step();
    in_abort = 0; in_valid = 0;
    @(negedge clk);
    check("abort_idle", {out_busy, out_done}, 2'b00);
    check("abort_loaded", out_layer_loaded, 3'b001);
    step();
    @(negedge clk);
    check("abort_no_done", out_done, 1'b0);

    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
